// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encodings and frame constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program image over a byte stream, writes it into instruction
// memory and releases the core from reset only once the XOR checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_t              r_state;
  logic [7:0]          r_cnt_hi;
  logic [7:0]          r_hi;
  logic [7:0]          r_csum;
  logic [15:0]         r_left;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_core_rst_n;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic [15:0]         w_count;
  logic [7:0]          w_csum_next;

  assign w_accept    = rx_valid && r_ready;
  assign w_count     = {r_cnt_hi, rx_data};
  assign w_csum_next = r_csum ^ rx_data;

  // Frame FSM; the write cycle blocks acceptance so address bump and next byte never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt_hi     <= 8'd0;
      r_hi         <= 8'd0;
      r_csum       <= 8'd0;
      r_left       <= 16'd0;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 16'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      if (r_we) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_accept) begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_data == MAGIC) begin
              r_state      <= ST_CNT_HI;
              r_core_rst_n <= 1'b0;
              r_done       <= 1'b0;
              r_err        <= 1'b0;
              r_addr       <= '0;
              r_csum       <= 8'd0;
            end
          end
          ST_CNT_HI: begin
            r_cnt_hi <= rx_data;
            r_state  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            r_left <= w_count;
            if (32'(w_count) > DEPTH) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            r_hi    <= rx_data;
            r_csum  <= w_csum_next;
            r_state <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            r_wdata <= {r_hi, rx_data};
            r_we    <= 1'b1;
            r_ready <= 1'b0;
            r_csum  <= w_csum_next;
            r_left  <= r_left - 16'd1;
            r_state <= (r_left == 16'd1) ? ST_CHECK : ST_DATA_HI;
          end
          ST_CHECK: begin
            if (rx_data == r_csum) begin
              r_state      <= ST_DONE;
              r_core_rst_n <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_done;
  assign load_error = r_err;

endmodule
